alu_core: RTL and testbench



---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_if.sv | 27 ++
 rtl/alu_add_sub.sv | 15 +
 rtl/alu_core.sv | 111 +++++++++++
 tb/tb_alu_core.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared types for the execute-stage ALU: opcode encoding and default datapath width.
package alu_pkg;

   localparam int ALU_WIDTH = 64;

   typedef enum logic [2:0] {
      OP_PASSB = 3'b000,
      OP_ZERO0 = 3'b001,
      OP_ADD   = 3'b010,
      OP_SUB   = 3'b011,
      OP_AND   = 3'b100,
      OP_OR    = 3'b101,
      OP_XOR   = 3'b110,
      OP_ZERO1 = 3'b111
   } alu_op_e;

   // Only ADD and SUB drive the carry/overflow flags.
   function automatic logic is_arith(input alu_op_e op);
      return (op == OP_ADD) || (op == OP_SUB);
   endfunction

endpackage

// File: rtl/alu_if.sv
// Operation request / registered result bundle between the issue logic and alu_core.
interface alu_if
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
);
   logic             in_valid;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [2:0]       sel;
   logic [WIDTH-1:0] result;
   logic             out_valid;
   logic             flag_n;
   logic             flag_z;
   logic             flag_c;
   logic             flag_v;

   modport master (
      output in_valid, a, b, sel,
      input  result, out_valid, flag_n, flag_z, flag_c, flag_v
   );

   modport slave (
      input  in_valid, a, b, sel,
      output result, out_valid, flag_n, flag_z, flag_c, flag_v
   );
endinterface

// File: rtl/alu_add_sub.sv
// One bit of the ripple adder; sub inverts b so that a chain with cin[0]=1 subtracts.
module add_sub (
   output logic sum,
   output logic cout,
   input  logic cin,
   input  logic a,
   input  logic b,
   input  logic sub
);
   logic b_eff;

   assign b_eff = b ^ sub;
   assign sum   = a ^ b_eff ^ cin;
   assign cout  = (a & b_eff) | (cin & (a ^ b_eff));
endmodule

// File: rtl/alu_core.sv
// Registered ALU for the execute stage: ripple add/sub plus logic ops, one-cycle latency.
// Define ALU_FLAGS_EN to build the N/Z/C/V flag registers; otherwise flags read as 0.
module alu_core
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
) (
   input  logic  clk,
   input  logic  rst_n,
   alu_if.slave  bus
);
   alu_op_e          op;
   logic [WIDTH-1:0] cin_w;
   logic [WIDTH-1:0] sum_w;
   logic [WIDTH-1:0] result_d;
   logic [WIDTH-1:0] result_q;
   logic             out_valid_q;
`ifdef ALU_FLAGS_EN
   logic             carry_msb;
`else
   logic             carry_unused;
`endif

   assign op       = alu_op_e'(bus.sel);
   assign cin_w[0] = bus.sel[0];

   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic cout_bit;

      add_sub u_add_sub (
         .sum  (sum_w[gi]),
         .cout (cout_bit),
         .cin  (cin_w[gi]),
         .a    (bus.a[gi]),
         .b    (bus.b[gi]),
         .sub  (bus.sel[0])
      );

      if (gi < WIDTH - 1) begin : g_chain
         assign cin_w[gi+1] = cout_bit;
      end else begin : g_msb
`ifdef ALU_FLAGS_EN
         assign carry_msb = cout_bit;
`else
         assign carry_unused = cout_bit;
`endif
      end
   end

   // Both arithmetic opcodes share the adder output; sel[0] already picked add vs sub.
   always_comb begin
      result_d = '0;
      case (op)
         OP_PASSB: result_d = bus.b;
         OP_ADD,
         OP_SUB:   result_d = sum_w;
         OP_AND:   result_d = bus.a & bus.b;
         OP_OR:    result_d = bus.a | bus.b;
         OP_XOR:   result_d = bus.a ^ bus.b;
         default:  result_d = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result_q    <= '0;
         out_valid_q <= 1'b0;
      end else begin
         out_valid_q <= bus.in_valid;
         if (bus.in_valid) begin
            result_q <= result_d;
         end
      end
   end

   assign bus.result    = result_q;
   assign bus.out_valid = out_valid_q;

`ifdef ALU_FLAGS_EN
   logic [3:0] flags_d;
   logic [3:0] flags_q;
   logic       arith;

   assign arith = is_arith(op);

   // Overflow: carry into the sign bit differs from carry out of it.
   assign flags_d = {result_d[WIDTH-1],
                     (result_d == '0),
                     arith & carry_msb,
                     arith & (carry_msb ^ cin_w[WIDTH-1])};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flags_q <= 4'b0000;
      end else if (bus.in_valid) begin
         flags_q <= flags_d;
      end
   end

   assign bus.flag_n = flags_q[3];
   assign bus.flag_z = flags_q[2];
   assign bus.flag_c = flags_q[1];
   assign bus.flag_v = flags_q[0];
`else
   assign bus.flag_n = 1'b0;
   assign bus.flag_z = 1'b0;
   assign bus.flag_c = 1'b0;
   assign bus.flag_v = 1'b0;
`endif

endmodule

// File: tb/tb_alu_core.sv
// Directed scoreboard bench for alu_core; expected flags collapse to 0 unless ALU_FLAGS_EN is set.
module tb_alu_core;
   import alu_pkg::*;

   localparam int W = 64;
`ifdef ALU_FLAGS_EN
   localparam bit FLAGS_ON = 1'b1;
`else
   localparam bit FLAGS_ON = 1'b0;
`endif

   typedef struct packed {
      logic [W-1:0] res;
      logic         n;
      logic         z;
      logic         c;
      logic         v;
   } exp_t;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   int   txn;
   exp_t sb[$];
   exp_t last_exp;

   alu_if #(.WIDTH(W)) bus ();

   alu_core #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic exp_t observed();
      exp_t o;
      o.res = bus.result;
      o.n   = bus.flag_n;
      o.z   = bus.flag_z;
      o.c   = bus.flag_c;
      o.v   = bus.flag_v;
      return o;
   endfunction

   // Monitor: every presented result is matched against the oldest expectation.
   always @(negedge clk) begin
      if (rst_n && bus.out_valid) begin
         exp_t e;
         exp_t o;
         checks++;
         o = observed();
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_out_valid: got res=%h nzcv=%b%b%b%b, required no output",
                     o.res, o.n, o.z, o.c, o.v);
         end else begin
            e = sb.pop_front();
            txn++;
            if (o !== e) begin
               errors++;
               $display("FAIL txn%0d: got res=%h nzcv=%b%b%b%b, required res=%h nzcv=%b%b%b%b",
                        txn, o.res, o.n, o.z, o.c, o.v, e.res, e.n, e.z, e.c, e.v);
            end else begin
               $display("txn%0d ok: res=%h nzcv=%b%b%b%b", txn, o.res, o.n, o.z, o.c, o.v);
            end
         end
      end
   end

   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] sel,
                        input logic [W-1:0] r, input logic n, input logic z,
                        input logic c, input logic v);
      exp_t e;
      e.res = r;
      e.n   = FLAGS_ON & n;
      e.z   = FLAGS_ON & z;
      e.c   = FLAGS_ON & c;
      e.v   = FLAGS_ON & v;
      sb.push_back(e);
      last_exp     = e;
      bus.in_valid = 1'b1;
      bus.a        = a;
      bus.b        = b;
      bus.sel      = sel;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic check_idle(input string name, input exp_t e);
      exp_t o;
      o = observed();
      checks++;
      if (bus.out_valid !== 1'b0 || o !== e) begin
         errors++;
         $display("FAIL %s: got valid=%b res=%h nzcv=%b%b%b%b, required valid=0 res=%h nzcv=%b%b%b%b",
                  name, bus.out_valid, o.res, o.n, o.z, o.c, o.v, e.res, e.n, e.z, e.c, e.v);
      end else begin
         $display("%s ok: res=%h", name, o.res);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t zero_e;
      zero_e       = '0;
      checks       = 0;
      errors       = 0;
      txn          = 0;
      rst_n        = 1'b0;
      bus.in_valid = 1'b0;
      bus.a        = '0;
      bus.b        = '0;
      bus.sel      = 3'b000;

      #3;
      check_idle("reset_state", zero_e);
      #9;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Reset asserted while a result is on the outputs must clear them without a clock edge.
      bus.in_valid = 1'b1;
      bus.a        = 64'd1;
      bus.b        = 64'd2;
      bus.sel      = OP_ADD;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.result !== 64'd3) begin
         errors++;
         $display("FAIL pre_reset_add: got valid=%b res=%h, required valid=1 res=%h",
                  bus.out_valid, bus.result, 64'd3);
      end
      #1;
      rst_n = 1'b0;
      #1;
      check_idle("async_reset", zero_e);
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      issue(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, OP_ADD, 64'h8000_0000_0000_0000, 1, 0, 0, 1);
      issue(64'd5, 64'd5, OP_SUB, 64'd0, 0, 1, 1, 0);
      issue(64'd3, 64'd5, OP_SUB, 64'hFFFF_FFFF_FFFF_FFFE, 1, 0, 0, 0);
      issue(64'hF0F0, 64'hFF00, OP_AND, 64'hF000, 0, 0, 0, 0);
      issue(64'hF0F0, 64'hFF00, OP_OR,  64'hFFF0, 0, 0, 0, 0);
      issue(64'hF0F0, 64'hFF00, OP_XOR, 64'h0FF0, 0, 0, 0, 0);
      issue(64'h1234, 64'hDEAD, OP_PASSB, 64'hDEAD, 0, 0, 0, 0);
      issue(64'h5555, 64'h7777, OP_ZERO0, 64'd0, 0, 1, 0, 0);
      issue(64'h5555, 64'h7777, OP_ZERO1, 64'd0, 0, 1, 0, 0);
      issue(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, OP_ADD, 64'd0, 0, 1, 1, 0);
      issue(64'h8000_0000_0000_0000, 64'd1, OP_SUB, 64'h7FFF_FFFF_FFFF_FFFF, 0, 0, 1, 1);
      issue(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, OP_AND,
            64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 0, 0);

      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check_idle($sformatf("hold%0d", i), last_exp);
      end

      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
